serial_adder_ctrl: RTL and testbench

Bit-serial multi-bit adder that sits directly upstream of the team's 1-bit full-adder cell. The block accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It feeds one operand bit pair per clock, LSB first, into a single full-adder instance, keeping the carry in a register between bits. It then presents the assembled WIDTH-bit sum and final carry-out on a valid/ready output.

---
 rtl/serial_adder_pkg.sv | 28 ++
 rtl/serial_adder_ctrl_if.sv | 31 +++
 rtl/full_adder_cell.sv | 17 +
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared state encoding and sizing helper for the bit-serial adder.
// Rev     : 1.0
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // clog2 with a floor of 1 so a counter always has at least one bit
    function automatic int cnt_width(input int width);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < width) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl_if
// Brief   : Operand/result valid-ready bundle for the bit-serial adder.
// Rev     : 1.0
// ============================================================================
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module  : full_adder_cell
// Brief   : Combinational 1-bit full adder.
// Rev     : 1.0
// ============================================================================
module full_adder_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      sum,
    output logic      cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Brief   : LSB-first bit-serial adder driving one full_adder_cell per clock.
// Rev     : 1.0
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int c_CW = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic [c_CW-1:0]    r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               w_s;
    logic               w_c;
    logic               w_last;

    full_adder_cell u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .sum  (w_s),
        .cout (w_c)
    );

    assign w_last = (r_cnt == c_CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid)  w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == RUN) || (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_adder_ctrl
// Brief   : Randomized self-checking bench for serial_adder_ctrl.
// Rev     : 1.0
// ============================================================================
module tb_serial_adder_ctrl;
    localparam int c_W = 8;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    serial_adder_ctrl_if #(.WIDTH(c_W)) bus ();

    serial_adder_ctrl #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer addition, split into {cout, sum}
    function automatic logic [c_W:0] ref_add(input logic [c_W-1:0] x, input logic [c_W-1:0] y, input logic c);
        int unsigned total;
        total = int'(x) + int'(y) + int'(c);
        return total[c_W:0];
    endfunction

    task automatic run_op(input logic [c_W-1:0] ta, input logic [c_W-1:0] tb_, input logic tc, input int hold);
        logic [c_W:0] exp;
        int t0;
        bit seen;
        exp = ref_add(ta, tb_, tc);
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a = ta; bus.b = tb_; bus.cin = tc; bus.in_valid = 1'b1;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        t0 = cyc;
        bus.in_valid = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
        check("busy_run", 32'(bus.busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("out_valid_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check("latency", 32'(cyc - t0), 32'(c_W));
        check("sum", 32'(bus.sum), 32'(exp[c_W-1:0]));
        check("cout", 32'(bus.cout), 32'(exp[c_W]));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = (h % 2 == 0);
            bus.a = 8'h77; bus.b = 8'h77; bus.cin = 1'b0;
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sum", 32'(bus.sum), 32'(exp[c_W-1:0]));
            check("bp_cout", 32'(bus.cout), 32'(exp[c_W]));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [c_W-1:0] qa [$];
        logic [c_W-1:0] qb [$];
        logic           qc [$];
        logic [c_W:0]   qexp [$];
        logic [c_W:0]   e;
        int             acc_cyc [$];
        int             idx;
        int             got;

        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b0, 0);
        run_op(8'h9C, 8'h4E, 1'b1, 5);

        // Abort after three RUN edges
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h3C, 8'hC3, 1'b0, 0);

        for (int r = 0; r < 20; r++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Back-to-back stream with in_valid held high
        for (int k = 0; k < 4; k++) begin
            qa.push_back(8'($urandom));
            qb.push_back(8'($urandom));
            qc.push_back(1'($urandom));
        end
        idx = 0; got = 0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 100 && got < 4; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                e = qexp.pop_front();
                check("b2b_sum", 32'(bus.sum), 32'(e[c_W-1:0]));
                check("b2b_cout", 32'(bus.cout), 32'(e[c_W]));
                got++;
            end
            if (bus.in_ready) begin
                if (idx < 4) begin
                    bus.a = qa[idx]; bus.b = qb[idx]; bus.cin = qc[idx];
                    bus.in_valid = 1'b1;
                    qexp.push_back(ref_add(qa[idx], qb[idx], qc[idx]));
                    acc_cyc.push_back(cyc);
                    idx++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_results", 32'(got), 32'd4);
        for (int k = 1; k < acc_cyc.size(); k++) begin
            check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(c_W + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
